// File: rtl/bus_master_arbiter_if.sv
// Bus-mastership bundle between the arbiter and the 68030 bus side: address strobe,
// CPU BR/BG/BGACK handshake, per-master request/grant and arbiter status.
interface bus_master_arbiter_if #(
  parameter int NREQ = 2
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            nAS;
  logic            nBG;
  logic [NREQ-1:0] nReq;
  logic            nBR;
  logic            nBGACK;
  logic [NREQ-1:0] nGnt;
  logic [OW-1:0]   owner;
  logic            busy;
  logic            timeoutErr;

  modport master (
    input  nAS, nBG, nReq,
    output nBR, nBGACK, nGnt, owner, busy, timeoutErr
  );

  modport slave (
    output nAS, nBG, nReq,
    input  nBR, nBGACK, nGnt, owner, busy, timeoutErr
  );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin 68030 bus-mastership arbiter for NREQ alternate masters: runs the CPU
// BR/BG/BGACK handshake, enforces a grant-to-first-strobe timeout and tenure preemption.
module bus_master_arbiter #(
  parameter int NREQ        = 2,
  parameter int GNT_TIMEOUT = 16,
  parameter int MAX_TENURE  = 256,
  parameter int CW          = 9
) (
  input  logic                 sysClk,
  input  logic                 sysReset,
  bus_master_arbiter_if.master bus
);
  localparam int              OW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0]   TO_LAST  = CW'(GNT_TIMEOUT - 1);
  localparam logic [CW-1:0]   TEN_LAST = CW'(MAX_TENURE - 1);
  localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]   next_ptr_s;
  logic [CW-1:0]   count_q, count_d;
  logic            start_seen_q, start_seen_d;
  logic            nbr_q, nbr_d;
  logic            nbgack_q, nbgack_d;
  logic [NREQ-1:0] ngnt_q, ngnt_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [OW:0]     pick_idle_s;
  logic [OW:0]     pick_other_s;

  // Returns {found, index} of the first low request scanning upward from start, modulo NREQ.
  function automatic logic [OW:0] rr_pick(
    input logic [NREQ-1:0] req_n,
    input logic [OW-1:0]   start,
    input logic            skip_en,
    input logic [OW-1:0]   skip
  );
    logic          found;
    logic [OW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = {OW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(start) + i) % NREQ;
      if (!found && !req_n[j] && !(skip_en && (j == int'(skip)))) begin
        found = 1'b1;
        idx   = OW'(j);
      end
    end
    return {found, idx};
  endfunction

  // Next-state and registered-output computation for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    count_d      = count_q;
    start_seen_d = start_seen_q;
    nbr_d        = nbr_q;
    nbgack_d     = nbgack_q;
    ngnt_d       = ngnt_q;
    timeout_d    = 1'b0;
    next_ptr_s   = (owner_q == OW'(NREQ - 1)) ? {OW{1'b0}} : owner_q + OW'(1);
    pick_idle_s  = rr_pick(bus.nReq, rr_ptr_q, 1'b0, owner_q);
    pick_other_s = rr_pick(bus.nReq, next_ptr_s, 1'b1, owner_q);

    case (state_q)
      IDLE: begin
        if (pick_idle_s[OW]) begin
          owner_d = pick_idle_s[OW-1:0];
          nbr_d   = 1'b0;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.nReq[owner_q]) begin
          nbr_d   = 1'b1;
          state_d = IDLE;
        end else if (!bus.nBG && bus.nAS) begin
          nbgack_d     = 1'b0;
          ngnt_d       = ~(ONE_HOT0 << owner_q);
          nbr_d        = 1'b1;
          count_d      = {CW{1'b0}};
          start_seen_d = 1'b0;
          state_d      = GRANT;
        end else begin
          state_d = REQ;
        end
      end
      GRANT: begin
        count_d      = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);
        start_seen_d = start_seen_q | ~bus.nAS;
        // Voluntary release outranks timeout, so a simultaneous release never flags an error.
        if (bus.nReq[owner_q]) begin
          ngnt_d  = {NREQ{1'b1}};
          state_d = RELEASE;
        end else if (!start_seen_q && (count_q == TO_LAST)) begin
          ngnt_d    = {NREQ{1'b1}};
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end else if ((count_q >= TEN_LAST) && pick_other_s[OW]) begin
          ngnt_d  = {NREQ{1'b1}};
          state_d = RELEASE;
        end else begin
          state_d = GRANT;
        end
      end
      RELEASE: begin
        if (bus.nAS) begin
          rr_ptr_d = next_ptr_s;
          if (pick_other_s[OW]) begin
            owner_d      = pick_other_s[OW-1:0];
            ngnt_d       = ~(ONE_HOT0 << pick_other_s[OW-1:0]);
            count_d      = {CW{1'b0}};
            start_seen_d = 1'b0;
            state_d      = GRANT;
          end else begin
            nbgack_d = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        nbr_d    = 1'b1;
        nbgack_d = 1'b1;
        ngnt_d   = {NREQ{1'b1}};
        state_d  = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state_q      <= IDLE;
      owner_q      <= {OW{1'b0}};
      rr_ptr_q     <= {OW{1'b0}};
      count_q      <= {CW{1'b0}};
      start_seen_q <= 1'b0;
      nbr_q        <= 1'b1;
      nbgack_q     <= 1'b1;
      ngnt_q       <= {NREQ{1'b1}};
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      count_q      <= count_d;
      start_seen_q <= start_seen_d;
      nbr_q        <= nbr_d;
      nbgack_q     <= nbgack_d;
      ngnt_q       <= ngnt_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.nBR        = nbr_q;
  assign bus.nBGACK     = nbgack_q;
  assign bus.nGnt       = ngnt_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = busy_q;
  assign bus.timeoutErr = timeout_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Self-checking bench for bus_master_arbiter: directed scenarios plus randomized bus
// activity compared every clock against a behavioural model of the arbitration rules.
module tb_bus_master_arbiter;
  localparam int NREQ        = 2;
  localparam int GNT_TIMEOUT = 16;
  localparam int MAX_TENURE  = 256;
  localparam int CW          = 9;

  localparam int PH_IDLE  = 0;
  localparam int PH_ASK   = 1;
  localparam int PH_HOLD  = 2;
  localparam int PH_DRAIN = 3;

  logic sysClk = 1'b0;
  logic sysReset;
  int   n_checks = 0;
  int   n_errors = 0;

  int   m_phase;
  int   m_owner;
  int   m_gnt;
  int   m_rr;
  int   m_held;
  bit   m_seen;
  bit   m_nbr;
  bit   m_nbgack;
  bit   m_to;

  bus_master_arbiter_if #(.NREQ(NREQ)) bus ();

  bus_master_arbiter #(
    .NREQ(NREQ),
    .GNT_TIMEOUT(GNT_TIMEOUT),
    .MAX_TENURE(MAX_TENURE),
    .CW(CW)
  ) dut (
    .sysClk(sysClk),
    .sysReset(sysReset),
    .bus(bus)
  );

  always #5 sysClk = ~sysClk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First requesting master at or after 'from' (modulo NREQ), ignoring 'skip'; -1 if none.
  function automatic int rr_pick(input int from, input int skip);
    int m;
    for (int k = 0; k < NREQ; k++) begin
      m = (from + k) % NREQ;
      if (m != skip && bus.nReq[m] === 1'b0) return m;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_gnt();
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    if (m_gnt < 0) return {NREQ{1'b1}};
    return ~(one << m_gnt);
  endfunction

  task automatic model_reset();
    m_phase  = PH_IDLE;
    m_owner  = 0;
    m_gnt    = -1;
    m_rr     = 0;
    m_held   = 0;
    m_seen   = 1'b0;
    m_nbr    = 1'b1;
    m_nbgack = 1'b1;
    m_to     = 1'b0;
  endtask

  task automatic model_step();
    int w;
    int other;
    bit leave;
    m_to = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        w = rr_pick(m_rr, -1);
        if (w >= 0) begin
          m_owner = w;
          m_nbr   = 1'b0;
          m_phase = PH_ASK;
        end
      end
      PH_ASK: begin
        if (bus.nReq[m_owner]) begin
          m_nbr   = 1'b1;
          m_phase = PH_IDLE;
        end else if (!bus.nBG && bus.nAS) begin
          m_nbgack = 1'b0;
          m_nbr    = 1'b1;
          m_gnt    = m_owner;
          m_held   = 0;
          m_seen   = 1'b0;
          m_phase  = PH_HOLD;
        end
      end
      PH_HOLD: begin
        other = rr_pick(m_owner + 1, m_owner);
        leave = 1'b0;
        if (bus.nReq[m_owner]) leave = 1'b1;
        else if (!m_seen && m_held == GNT_TIMEOUT - 1) begin
          leave = 1'b1;
          m_to  = 1'b1;
        end else if (m_held >= MAX_TENURE - 1 && other >= 0) leave = 1'b1;
        m_held++;
        if (!bus.nAS) m_seen = 1'b1;
        if (leave) begin
          m_gnt   = -1;
          m_phase = PH_DRAIN;
        end
      end
      PH_DRAIN: begin
        if (bus.nAS) begin
          m_rr = (m_owner + 1) % NREQ;
          w    = rr_pick(m_rr, m_owner);
          if (w >= 0) begin
            m_owner = w;
            m_gnt   = w;
            m_held  = 0;
            m_seen  = 1'b0;
            m_phase = PH_HOLD;
          end else begin
            m_nbgack = 1'b1;
            m_phase  = PH_IDLE;
          end
        end
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  task automatic compare_model();
    check_eq("model_nBR", bus.nBR, m_nbr);
    check_eq("model_nBGACK", bus.nBGACK, m_nbgack);
    check_eq("model_nGnt", bus.nGnt, exp_gnt());
    check_eq("model_owner", bus.owner, m_owner);
    check_eq("model_busy", bus.busy, m_phase != PH_IDLE);
    check_eq("model_timeoutErr", bus.timeoutErr, m_to);
  endtask

  task automatic tick();
    @(posedge sysClk);
    model_step();
    #1;
    compare_model();
  endtask

  // Asserts reset between clock edges and checks the outputs respond before any edge.
  task automatic pulse_reset(input string tag);
    sysReset = 1'b1;
    #1;
    check_eq({tag, "_nGnt"}, bus.nGnt, {NREQ{1'b1}});
    check_eq({tag, "_nBGACK"}, bus.nBGACK, 1'b1);
    check_eq({tag, "_nBR"}, bus.nBR, 1'b1);
    check_eq({tag, "_busy"}, bus.busy, 1'b0);
    check_eq({tag, "_timeoutErr"}, bus.timeoutErr, 1'b0);
    check_eq({tag, "_owner"}, bus.owner, 0);
    model_reset();
    #1;
    sysReset = 1'b0;
  endtask

  initial begin
    int as_low_pct;
    int flip_pm;

    sysReset = 1'b1;
    bus.nReq = 2'b11;
    bus.nBG  = 1'b1;
    bus.nAS  = 1'b1;
    model_reset();
    #2;
    pulse_reset("rst");

    // Single request from master 0.
    bus.nReq = 2'b10;
    tick();
    check_eq("single_nBR_low", bus.nBR, 1'b0);
    bus.nBG = 1'b0;
    tick();
    check_eq("single_nGnt", bus.nGnt, 2'b10);
    check_eq("single_nBGACK", bus.nBGACK, 1'b0);
    check_eq("single_nBR_high", bus.nBR, 1'b1);
    bus.nBG  = 1'b1;
    bus.nReq = 2'b11;
    tick();
    check_eq("single_rel_nGnt", bus.nGnt, 2'b11);
    tick();
    check_eq("single_rel_nBGACK", bus.nBGACK, 1'b1);
    check_eq("single_rel_busy", bus.busy, 1'b0);

    // Round-robin hand-off from master 0 to master 1.
    pulse_reset("rst_handoff");
    bus.nReq = 2'b00;
    tick();
    bus.nBG = 1'b0;
    tick();
    check_eq("handoff_first_gnt", bus.nGnt, 2'b10);
    bus.nBG  = 1'b1;
    bus.nReq = 2'b01;
    tick();
    check_eq("handoff_gap_nBGACK", bus.nBGACK, 1'b0);
    check_eq("handoff_gap_nBR", bus.nBR, 1'b1);
    tick();
    check_eq("handoff_nGnt", bus.nGnt, 2'b01);
    check_eq("handoff_owner", bus.owner, 1);
    check_eq("handoff_nBGACK", bus.nBGACK, 1'b0);
    check_eq("handoff_nBR", bus.nBR, 1'b1);
    bus.nReq = 2'b11;
    tick();
    tick();

    // Grant timeout: master 1 granted, nAS never asserted.
    pulse_reset("rst_timeout");
    bus.nReq = 2'b01;
    tick();
    bus.nBG = 1'b0;
    tick();
    check_eq("timeout_gnt", bus.nGnt, 2'b01);
    bus.nBG = 1'b1;
    for (int k = 1; k < GNT_TIMEOUT; k++) begin
      tick();
      check_eq("timeout_quiet", bus.timeoutErr, 1'b0);
      check_eq("timeout_held", bus.nGnt, 2'b01);
    end
    tick();
    check_eq("timeout_pulse", bus.timeoutErr, 1'b1);
    tick();
    check_eq("timeout_pulse_end", bus.timeoutErr, 1'b0);
    check_eq("timeout_revoked", bus.nGnt, 2'b11);
    bus.nReq = 2'b11;
    tick();
    tick();

    // Preemption: master 0 holds with nAS active, master 1 requests at clock 10.
    pulse_reset("rst_preempt");
    bus.nReq = 2'b10;
    tick();
    bus.nBG = 1'b0;
    tick();
    bus.nBG = 1'b1;
    bus.nAS = 1'b0;
    for (int k = 1; k < MAX_TENURE; k++) begin
      tick();
      check_eq("preempt_hold", bus.nGnt, 2'b10);
      if (k == 10) bus.nReq = 2'b00;
    end
    tick();
    check_eq("preempt_revoke", bus.nGnt, 2'b11);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("preempt_drain", bus.nGnt, 2'b11);
      check_eq("preempt_drain_nBGACK", bus.nBGACK, 1'b0);
    end
    bus.nAS = 1'b1;
    tick();
    check_eq("preempt_new_gnt", bus.nGnt, 2'b01);
    check_eq("preempt_owner", bus.owner, 1);
    bus.nReq = 2'b11;
    tick();
    tick();

    // Withdraw before grant.
    pulse_reset("rst_withdraw");
    bus.nReq = 2'b10;
    tick();
    bus.nReq = 2'b11;
    tick();
    check_eq("withdraw_nBR", bus.nBR, 1'b1);
    check_eq("withdraw_busy", bus.busy, 1'b0);
    check_eq("withdraw_nGnt", bus.nGnt, 2'b11);

    // Reset in the middle of a tenure.
    bus.nReq = 2'b10;
    tick();
    bus.nBG = 1'b0;
    tick();
    bus.nBG = 1'b1;
    bus.nAS = 1'b0;
    tick();
    tick();
    check_eq("midrst_before", bus.nGnt, 2'b10);
    pulse_reset("midrst");
    bus.nReq = 2'b11;
    bus.nAS  = 1'b1;

    // Randomized episodes: rare strobes (timeouts), busy bus, sticky owners (preemption).
    for (int ep = 0; ep < 12; ep++) begin
      as_low_pct = (ep % 3 == 0) ? 3 : ((ep % 3 == 1) ? 50 : 90);
      flip_pm    = (ep % 3 == 2) ? 2 : 30;
      for (int c = 0; c < 250; c++) begin
        for (int i = 0; i < NREQ; i++) begin
          if ($urandom_range(999) < flip_pm) bus.nReq[i] = ~bus.nReq[i];
        end
        bus.nBG = ($urandom_range(99) < 60) ? 1'b0 : 1'b1;
        bus.nAS = ($urandom_range(99) < as_low_pct) ? 1'b0 : 1'b1;
        tick();
        if ($urandom_range(999) == 0) pulse_reset("rand_rst");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
